// File: rtl/frequency_analyzer.sv
// -----------------------------------------------------------------------------
// frequency_analyzer
//
// Measurement stage for one analyzer channel. Between a start strobe falling
// edge and a stop strobe rising edge it counts:
//   - window_ticks : clocks spent in the measurement window
//   - high_ticks   : clocks with the synchronised sample high
//   - edge_count   : rising edges of the synchronised sample
// Results are latched at window close and held behind a valid/ack handshake
// for the downstream frequency/duty calculator.
//
// Ports
//   clock         system clock, all logic on the rising edge
//   reset         asynchronous, active-high; clears all state and outputs
//   enable        block enable; low aborts any window in progress
//   start         window start strobe (synchronous to clock)
//   stop          window stop strobe (synchronous to clock)
//   sample_in     measured signal, asynchronous to clock
//   result_ack    consumer accepts the current result
//   busy          high while a window is being measured
//   result_valid  result registers hold an unacknowledged result
//   edge_count    rising edges of sample_in inside the window
//   high_ticks    clocks with synchronised sample_in high inside the window
//   window_ticks  window length in clocks
//   overflow      a counter saturated in the latched window
//   overrun       sticky; a result was replaced before it was acknowledged
// -----------------------------------------------------------------------------
module frequency_analyzer #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     sample_in,
    input  logic                     result_ack,
    output logic                     busy,
    output logic                     result_valid,
    output logic [COUNTER_WIDTH-1:0] edge_count,
    output logic [COUNTER_WIDTH-1:0] high_ticks,
    output logic [COUNTER_WIDTH-1:0] window_ticks,
    output logic                     overflow,
    output logic                     overrun
);

    localparam int unsigned CW  = COUNTER_WIDTH;
    localparam int unsigned CW1 = COUNTER_WIDTH + 1;
    localparam int unsigned SW  = SYNC_STAGES;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // One complete measurement: working set and latched result share this shape.
    typedef struct packed {
        logic          ovf;
        logic [CW-1:0] edges;
        logic [CW-1:0] high;
        logic [CW-1:0] window;
    } meas_t;

    state_t        state;
    state_t        state_next;

    logic [SW-1:0] sync_q;
    logic          s_sync;
    logic          sample_prev;
    logic          start_prev;
    logic          stop_prev;

    logic          start_fall_c;
    logic          stop_rise_c;
    logic          s_rise_c;

    logic          clear_c;
    logic          count_c;
    logic          latch_c;

    logic [CW:0]   win_sum_c;
    logic [CW:0]   high_sum_c;
    logic [CW:0]   edge_sum_c;

    meas_t         work_q;
    meas_t         work_next_c;
    meas_t         result_q;

    // Sample synchroniser and one-cycle history for edge detection.
    // start/stop come from the same clock domain and are used directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            sample_prev <= 1'b0;
            start_prev  <= 1'b0;
            stop_prev   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SW-2:0], sample_in};
            sample_prev <= s_sync;
            start_prev  <= start;
            stop_prev   <= stop;
        end
    end

    assign s_sync       = sync_q[SW-1];
    assign start_fall_c = start_prev & ~start;
    assign stop_rise_c  = ~stop_prev & stop;
    assign s_rise_c     = s_sync & ~sample_prev;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. Dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start)        state_next = ST_ARMED;
                ST_ARMED:   if (start_fall_c) state_next = ST_MEASURE;
                ST_MEASURE: if (stop_rise_c)  state_next = ST_IDLE;
                default:                      state_next = ST_IDLE;
            endcase
        end
    end

    // FSM datapath controls. A stop rise coinciding with the start fall is
    // ignored because it arrives while still ARMED.
    always_comb begin
        clear_c = 1'b0;
        count_c = 1'b0;
        latch_c = 1'b0;
        if (enable) begin
            case (state)
                ST_ARMED: begin
                    clear_c = start_fall_c;
                end
                ST_MEASURE: begin
                    count_c = ~stop_rise_c;
                    latch_c = stop_rise_c;
                end
                default: ;
            endcase
        end
    end

    // busy mirrors the MEASURE state as a registered output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next == ST_MEASURE);
        end
    end

    // Saturating increments: the carry out of each widened sum marks an
    // increment that would wrap, so the counter holds at max and flags ovf.
    always_comb begin
        win_sum_c  = {1'b0, work_q.window} + CW1'(1);
        high_sum_c = {1'b0, work_q.high}   + CW1'(s_sync);
        edge_sum_c = {1'b0, work_q.edges}  + CW1'(s_rise_c);

        work_next_c        = work_q;
        work_next_c.window = win_sum_c[CW]  ? CNT_MAX : win_sum_c[CW-1:0];
        work_next_c.high   = high_sum_c[CW] ? CNT_MAX : high_sum_c[CW-1:0];
        work_next_c.edges  = edge_sum_c[CW] ? CNT_MAX : edge_sum_c[CW-1:0];
        work_next_c.ovf    = work_q.ovf | win_sum_c[CW] | high_sum_c[CW]
                             | edge_sum_c[CW];
    end

    // Working counters: cleared on window open, advanced every window cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work_q <= '0;
        end else if (clear_c) begin
            work_q <= '0;
        end else if (count_c) begin
            work_q <= work_next_c;
        end
    end

    // Result registers and handshake. A new latch always wins; it only counts
    // as an overrun if the previous result was neither acked before nor in the
    // latch cycle itself.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q     <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (latch_c) begin
            result_q     <= work_q;
            result_valid <= 1'b1;
            if (result_valid && !result_ack) begin
                overrun <= 1'b1;
            end
        end else if (result_valid && result_ack) begin
            result_valid <= 1'b0;
        end
    end

    assign edge_count   = result_q.edges;
    assign high_ticks   = result_q.high;
    assign window_ticks = result_q.window;
    assign overflow     = result_q.ovf;

endmodule

// File: tb/tb_frequency_analyzer.sv
// -----------------------------------------------------------------------------
// tb_frequency_analyzer
//
// Drives two analyzers (32-bit and 8-bit counters) from the same stimulus.
// The stimulus records the sample value seen at every clock edge; when a
// window closes, the expected counts are computed from that history and queued
// with the edge at which the result must appear. A monitor on the falling
// edge pops and compares.
// -----------------------------------------------------------------------------
module tb_frequency_analyzer;

    localparam int unsigned CW     = 32;
    localparam int unsigned CW8    = 8;
    localparam int unsigned MAXCYC = 65000;

    logic           clock;
    logic           reset;
    logic           enable;
    logic           start;
    logic           stop;
    logic           sample_in;
    logic           result_ack;

    logic           busy, result_valid, overflow, overrun;
    logic [CW-1:0]  edge_count, high_ticks, window_ticks;
    logic           busy8, result_valid8, overflow8, overrun8;
    logic [CW8-1:0] edge_count8, high_ticks8, window_ticks8;

    typedef struct {
        int unsigned       edge_no;
        longint unsigned   win;
        longint unsigned   high;
        longint unsigned   edges;
        bit                ovr;
    } exp_t;

    exp_t        sbq[$];
    bit          samp [0:65535];   // sample_in value sampled at each edge
    int unsigned cyc;
    int          smode;
    int unsigned half;
    int          checks;
    int          fails;
    bit          pending;
    bit          exp_ovr;

    frequency_analyzer #(.COUNTER_WIDTH(CW), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .stop(stop), .sample_in(sample_in), .result_ack(result_ack),
        .busy(busy), .result_valid(result_valid), .edge_count(edge_count),
        .high_ticks(high_ticks), .window_ticks(window_ticks),
        .overflow(overflow), .overrun(overrun)
    );

    frequency_analyzer #(.COUNTER_WIDTH(CW8), .SYNC_STAGES(2)) dut8 (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .stop(stop), .sample_in(sample_in), .result_ack(result_ack),
        .busy(busy8), .result_valid(result_valid8), .edge_count(edge_count8),
        .high_ticks(high_ticks8), .window_ticks(window_ticks8),
        .overflow(overflow8), .overrun(overrun8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint unsigned sat8(input longint unsigned v);
        return (v > 255) ? 255 : v;
    endfunction

    // Advance one clock edge, then set the sample for the following edge.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (cyc >= MAXCYC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXCYC);
            $fatal(1, "cycle budget exhausted");
        end
        case (smode)
            0:       sample_in = 1'b0;
            1:       sample_in = 1'b1;
            2:       sample_in = 1'($urandom_range(0, 1));
            default: sample_in = 1'(((cyc + 1) / half) % 2);
        endcase
        samp[cyc + 1] = sample_in;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_valid"},  result_valid, 0);
        check({tag, "_edges"},  edge_count, 0);
        check({tag, "_high"},   high_ticks, 0);
        check({tag, "_window"}, window_ticks, 0);
        check({tag, "_ovf"},    overflow, 0);
        check({tag, "_ovr"},    overrun, 0);
        check({tag, "_busy8"},  busy8, 0);
        check({tag, "_valid8"}, result_valid8, 0);
        check({tag, "_edges8"}, edge_count8, 0);
        check({tag, "_high8"},  high_ticks8, 0);
        check({tag, "_win8"},   window_ticks8, 0);
        check({tag, "_ovf8"},   overflow8, 0);
        check({tag, "_ovr8"},   overrun8, 0);
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        pending = 1'b0;
        check("ack_clears_valid",  result_valid, 0);
        check("ack_clears_valid8", result_valid8, 0);
        check("overrun_after_ack", overrun, exp_ovr);
    endtask

    // One full window of n counted clocks.
    // ack_mode: 0 = leave unacked, 1 = ack in the latch cycle, 2 = ack later.
    task automatic run_window(input int unsigned n, input int ack_mode,
                              input bit simul_stop, input bit restart);
        int unsigned     t0;
        exp_t            x;
        longint unsigned h;
        longint unsigned e;
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = simul_stop;
        tick();
        t0 = cyc;
        check("busy_on", busy, 1);
        stop = 1'b0;
        for (int unsigned i = 1; i <= n; i++) begin
            start = restart && (i == n / 2);
            tick();
        end
        start      = 1'b0;
        stop       = 1'b1;
        result_ack = (ack_mode == 1);
        tick();
        stop       = 1'b0;
        result_ack = 1'b0;
        // Counted edges t0+1..t0+n see the sample two edges late.
        h = 0;
        e = 0;
        for (int unsigned k = t0 + 1; k <= t0 + n; k++) begin
            if (samp[k - 2]) begin
                h++;
                if (!samp[k - 3]) e++;
            end
        end
        if (pending && ack_mode != 1) exp_ovr = 1'b1;
        pending   = 1'b1;
        x.edge_no = cyc;
        x.win     = n;
        x.high    = h;
        x.edges   = e;
        x.ovr     = exp_ovr;
        sbq.push_back(x);
        check("busy_off", busy, 0);
        if (ack_mode == 2) begin
            repeat ($urandom_range(0, 3)) tick();
            do_ack();
        end
    endtask

    task automatic abort_window(input int unsigned k);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (k) tick();
        enable = 1'b0;
        tick();
        check("abort_busy",  busy, 0);
        check("abort_valid", result_valid, pending);
        enable = 1'b1;
        tick();
        check("abort_idle", busy, 0);
    endtask

    // Monitor: compare each queued result exactly at its latch edge.
    initial begin
        exp_t x;
        bit   valid_d;
        valid_d = 1'b0;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0 && sbq[0].edge_no < cyc) begin
                check("result_missing", cyc, sbq[0].edge_no);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].edge_no == cyc) begin
                x = sbq.pop_front();
                check("res_valid",   result_valid, 1);
                check("res_window",  window_ticks, x.win);
                check("res_high",    high_ticks, x.high);
                check("res_edges",   edge_count, x.edges);
                check("res_ovf",     overflow, (x.win > 64'hFFFF_FFFF) ? 1 : 0);
                check("res_overrun", overrun, x.ovr);
                check("res8_valid",  result_valid8, 1);
                check("res8_window", window_ticks8, sat8(x.win));
                check("res8_high",   high_ticks8, sat8(x.high));
                check("res8_edges",  edge_count8, sat8(x.edges));
                check("res8_ovf",    overflow8, (x.win > 255) ? 1 : 0);
                check("res8_overrun", overrun8, x.ovr);
            end else if (result_valid && !valid_d) begin
                check("unexpected_result", result_valid, 0);
            end
            valid_d = result_valid;
        end
    end

    initial begin
        checks     = 0;
        fails      = 0;
        cyc        = 0;
        smode      = 0;
        half       = 5;
        pending    = 1'b0;
        exp_ovr    = 1'b0;
        reset      = 1'b1;
        enable     = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        sample_in  = 1'b0;
        result_ack = 1'b0;
        for (int i = 0; i < 65536; i++) samp[i] = 1'b0;

        tick();
        check_zero("reset");
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        repeat (4) tick();

        // 50% square wave, period 10 clocks.
        smode = 3;
        half  = 5;
        run_window(1000, 2, 1'b0, 1'b0);

        // Constant high, then constant low.
        smode = 1;
        repeat (4) tick();
        run_window(1000, 2, 1'b0, 1'b0);
        smode = 0;
        repeat (4) tick();
        run_window(1000, 2, 1'b0, 1'b0);

        // Ack coincides with the second latch: no overrun.
        smode = 2;
        run_window(40, 0, 1'b0, 1'b0);
        run_window(37, 1, 1'b0, 1'b0);
        check("ovr_ack_same_cycle", overrun, 0);
        do_ack();

        // Two unacked windows: overrun set and sticky.
        run_window(25, 0, 1'b1, 1'b1);
        run_window(31, 0, 1'b0, 1'b0);
        check("ovr_two_windows", overrun, 1);
        do_ack();

        // Saturation boundary on the 8-bit instance.
        smode = 1;
        run_window(255, 2, 1'b0, 1'b0);
        run_window(256, 2, 1'b0, 1'b0);
        run_window(300, 2, 1'b0, 1'b0);

        // Enable dropped mid-window, then a normal window.
        smode = 3;
        half  = 3;
        abort_window(20);
        run_window(60, 2, 1'b0, 1'b0);
        run_window(15, 0, 1'b0, 1'b0);
        abort_window(5);
        do_ack();

        // Asynchronous reset mid-window.
        smode = 0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        sbq.delete();
        pending = 1'b0;
        exp_ovr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("post_reset_idle", busy, 0);
        run_window(12, 2, 1'b0, 1'b0);

        // Randomised windows.
        for (int it = 0; it < 25; it++) begin
            smode = $urandom_range(0, 3);
            half  = $urandom_range(1, 8);
            if ($urandom_range(0, 5) == 0) abort_window($urandom_range(0, 20));
            run_window($urandom_range(1, 260), $urandom_range(0, 2),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end
        do_ack();
        repeat (3) tick();
        check("queue_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
